if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry fetch-to-decode instruction queue with valid/ready handshakes on both sides.
- Decouples fetch from decode stalls.
- Supports trap flush and branch/JAL flush with fixed priority.
- Presents a NOP bubble to decode whenever the queue is empty or being flushed.

Parameters:
- XLEN, 32, width of PC and instruction fields.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0); width XLEN.
- TRAP_PC, 32'h00000000, PC value driven on out_pc while empty after a trap flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents pc/instr.
- in_ready  out  1  queue can accept; equals !full (registered state only, no combinational path from out side).
- in_pc  in  XLEN  PC of fetched instruction.
- in_instr  in  XLEN  fetched instruction.
- out_valid  out  1  head entry valid (queue non-empty).
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  XLEN  head PC; see Behaviour when empty.
- out_instr  out  XLEN  head instruction; NOP_INSTR when empty.
- stall  in  1  hazard hold; blocks pop regardless of out_ready.
- flush_trap  in  1  trap flush, highest priority.
- flush_branch  in  1  taken-branch flush.
- flush_jal  in  1  JAL flush.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0) plus a separate count register; full = (count==DEPTH), empty = (count==0).
- Reset (reset=1 at edge):
  - rd_ptr = wr_ptr = count = 0.
  - last_pc = TRAP_PC.
  - Outputs the next cycle: out_valid=0, out_instr=NOP_INSTR, out_pc=TRAP_PC, in_ready=1, count=0.
  - Reset overrides every other input.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready & !stall.
- Priority per cycle, highest first:
  1. reset.
  2. flush_trap: clear queue (pointers and count to 0); last_pc = TRAP_PC; push and pop ignored.
  3. flush_branch | flush_jal: clear queue; last_pc = in_pc; push and pop ignored. Same-cycle fetch data is dropped because it is on the wrong path.
  4. Normal operation: push and pop act independently.
     - push only: count+1.
     - pop only: count-1.
     - both: count unchanged, both pointers advance.
- Latency: an entry pushed at edge t is visible on out_* after edge t, i.e. in cycle t+1. No same-cycle bypass from in_* to out_*.
- Output muxing (combinational from state):
  - Non-empty: out_pc/out_instr = mem[rd_ptr].
  - Empty: out_instr = NOP_INSTR, out_pc = last_pc.
  - last_pc is updated on every pop to the popped PC, and on flushes as listed above.
- Boundary conditions:
  - Full: in_ready=0, so no push that cycle. Push+pop when full cannot occur, because in_ready is not credit-forwarded from pop.
  - Empty: out_valid=0, so pop is impossible; out_ready is ignored.
  - stall with out_ready=1: head is held and out_* is stable; pushes still accepted if not full.
  - Flush while stall=1: the flush still takes effect; flush outranks stall.
  - flush_trap and flush_branch together: trap behaviour only (last_pc = TRAP_PC).
  - Reset mid-stream: all entries discarded; no partial state survives.
- Storage array contents need no reset; only pointers, count and last_pc are reset.

Test Plan:
- Reset then idle: hold reset=1 for 2 cycles, release -> out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, count=0.
- Fill to full (DEPTH=4): push pc 0x100,0x104,0x108,0x10C with out_ready=0 -> count reaches 4, in_ready=0 in cycle 5, out_pc=0x100 from cycle after first push; a 5th in_valid is not accepted.
- Simultaneous push/pop with pointer wrap: stream 12 instructions with in_valid=out_ready=1 -> out order matches input order, each output 1 cycle after its push, count stays 1, pointers wrap cleanly.
- Stall hold: with queue holding 0x200/0x204, drive stall=1, out_ready=1 for 3 cycles -> out_pc stays 0x200 and out_instr is stable; release -> 0x200 pops, then 0x204.
- Branch flush with concurrent push: count=3, flush_branch=1, in_valid=1, in_pc=0x300 -> next cycle count=0, out_valid=0, out_instr=NOP, out_pc=0x300; the 0x300 entry is not enqueued.
- Trap outranks branch and stall: count=2, flush_trap=flush_branch=stall=1 -> next cycle count=0, out_pc=TRAP_PC=0, out_instr=NOP; pushes resume normally the following cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch-to-decode instruction queue with valid/ready
// handshakes on both sides, prioritised trap/branch/JAL flushes, and a NOP
// bubble presented to decode whenever the queue is empty.
module if_id_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter logic [XLEN-1:0] TRAP_PC   = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  input  logic                       stall,
  input  logic                       flush_trap,
  input  logic                       flush_branch,
  input  logic                       flush_jal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;

  // Status, handshakes and the head/bubble output mux, all from registered state
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready & !stall;
    count     = count_q;
    if (empty) begin
      out_pc    = last_pc_q;
      out_instr = NOP_INSTR;
    end else begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
    end
  end

  // Next-state: trap flush beats branch/JAL flush, which beats normal push/pop
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    wr_en     = 1'b0;
    if (flush_trap) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      last_pc_d = TRAP_PC;
    end else if (flush_branch | flush_jal) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      last_pc_d = in_pc;
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        last_pc_d = pc_mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= TRAP_PC;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        stall;
  logic        flush_trap;
  logic        flush_branch;
  logic        flush_jal;
  logic [2:0]  count;

  int compared   = 0;
  int mismatched = 0;

  if_id_queue #(
    .XLEN(32), .DEPTH(4), .NOP_INSTR(32'h00000013), .TRAP_PC(32'h00000000)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .stall(stall), .flush_trap(flush_trap), .flush_branch(flush_branch),
    .flush_jal(flush_jal), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction word tagged with its PC so ordering errors are visible
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hABCD0000 ^ pc;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ordy,
                               input logic stl, input logic ft, input logic fb,
                               input logic fj);
    in_valid     = v;
    in_pc        = pc;
    in_instr     = instr_of(pc);
    out_ready    = ordy;
    stall        = stl;
    flush_trap   = ft;
    flush_branch = fb;
    flush_jal    = fj;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] einstr, input logic erdy,
                             input logic [2:0] ecnt);
    compared++;
    assert (out_valid === ev) else begin
      mismatched++;
      $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, ev);
    end
    compared++;
    assert (out_pc === epc) else begin
      mismatched++;
      $error("[TB] FAIL %s out_pc observed=%h expected=%h", tag, out_pc, epc);
    end
    compared++;
    assert (out_instr === einstr) else begin
      mismatched++;
      $error("[TB] FAIL %s out_instr observed=%h expected=%h", tag, out_instr, einstr);
    end
    compared++;
    assert (in_ready === erdy) else begin
      mismatched++;
      $error("[TB] FAIL %s in_ready observed=%b expected=%b", tag, in_ready, erdy);
    end
    compared++;
    assert (count === ecnt) else begin
      mismatched++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, count, ecnt);
    end
  endtask

  initial begin
    // Reset held for two cycles, then idle
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    checkOutput("reset", 1'b0, 32'h0, NOP, 1'b1, 3'd0);
    step();
    checkOutput("idle", 1'b0, 32'h0, NOP, 1'b1, 3'd0);

    // Fill to full with decode not ready
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("fill", 1'b1, 32'h100, instr_of(32'h100), (i < 3), 3'(i + 1));
    end
    // Fifth fetch must be refused while full
    applyStimulus(1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("full_refuse", 1'b1, 32'h100, instr_of(32'h100), 1'b0, 3'd4);

    // Drain in order; once empty the bubble carries the last popped PC
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("drain", 1'b1, 32'h100 + 32'(4 * i), instr_of(32'h100 + 32'(4 * i)),
                  1'b1, 3'(4 - i));
    end
    step();
    checkOutput("drain_empty", 1'b0, 32'h10C, NOP, 1'b1, 3'd0);

    // Streaming push+pop: occupancy stays at one and pointers wrap three times
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("stream", 1'b1, 32'h400 + 32'(4 * i), instr_of(32'h400 + 32'(4 * i)),
                  1'b1, 3'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stream_end", 1'b0, 32'h42C, NOP, 1'b1, 3'd0);

    // Stall hold: load 0x200/0x204, then stall with out_ready while pushing 0x208
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stall_load", 1'b1, 32'h200, instr_of(32'h200), 1'b1, 3'd2);
    applyStimulus(1'b1, 32'h208, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stall_push", 1'b1, 32'h200, instr_of(32'h200), 1'b1, 3'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stall_hold2", 1'b1, 32'h200, instr_of(32'h200), 1'b1, 3'd3);
    step();
    checkOutput("stall_hold3", 1'b1, 32'h200, instr_of(32'h200), 1'b1, 3'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stall_rel1", 1'b1, 32'h204, instr_of(32'h204), 1'b1, 3'd2);
    step();
    checkOutput("stall_rel2", 1'b1, 32'h208, instr_of(32'h208), 1'b1, 3'd1);
    step();
    checkOutput("stall_rel3", 1'b0, 32'h208, NOP, 1'b1, 3'd0);

    // Branch flush with concurrent fetch: queue cleared, 0x300 not enqueued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("br_load", 1'b1, 32'h500, instr_of(32'h500), 1'b1, 3'd3);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("br_flush", 1'b0, 32'h300, NOP, 1'b1, 3'd0);

    // JAL flush during stall with decode ready
    applyStimulus(1'b1, 32'h520, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h340, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("jal_flush", 1'b0, 32'h340, NOP, 1'b1, 3'd0);

    // Trap outranks branch and stall, then pushes resume
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("trap_load", 1'b1, 32'h600, instr_of(32'h600), 1'b1, 3'd2);
    applyStimulus(1'b1, 32'h700, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("trap_flush", 1'b0, 32'h0, NOP, 1'b1, 3'd0);
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("trap_resume", 1'b1, 32'h800, instr_of(32'h800), 1'b1, 3'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("trap_pop", 1'b0, 32'h800, NOP, 1'b1, 3'd0);

    // Reset mid-stream discards entries and restores the trap PC
    applyStimulus(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h904, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_reset", 1'b0, 32'h0, NOP, 1'b1, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
